// File: rtl/usr_pkg.sv
// Shared op codes, FSM states and op classification for the universal shift register.
// USR_ROT_EN selects whether ROR/ROL count as step operations.
package usr_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHR  = 3'd2,
      OP_SHL  = 3'd3,
      OP_ROR  = 3'd4,
      OP_ROL  = 3'd5,
      OP_ASR  = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Ops that move bits one position per clock; everything else completes on accept.
   function automatic logic is_step_op(input op_e o);
      logic r;
      case (o)
         OP_SHR, OP_SHL, OP_ASR: r = 1'b1;
`ifdef USR_ROT_EN
         OP_ROR, OP_ROL:         r = 1'b1;
`endif
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step shift/rotate: next register value for one step of op.
// Rotate muxing exists only when USR_ROT_EN is defined; otherwise codes 4/5 pass q through.
module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  op_e              op,
   input  logic             d_sr,
   input  logic             d_sl,
   output logic [WIDTH-1:0] q_nxt
);

   always_comb begin
      q_nxt = q;
      case (op)
         OP_SHR:  q_nxt = {d_sr, q[WIDTH-1:1]};
         OP_SHL:  q_nxt = {q[WIDTH-2:0], d_sl};
         OP_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROT_EN
         OP_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
         OP_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
         default: q_nxt = q;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: multi-step shift/rotate under start/busy/done, one step per clock.
// First step on the accept edge; start is ignored while busy; rotates need USR_ROT_EN.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] cnt,
   input  logic [WIDTH-1:0] D,
   input  logic             D_sr,
   input  logic             D_sl,
   output logic [WIDTH-1:0] Q,
   output logic             so_r,
   output logic             so_l,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_e           state, state_nxt;
   op_e              op_r, op_d, op_in, step_op;
   logic [CNT_W-1:0] rem, rem_d;
   logic [WIDTH-1:0] q_r, q_d, step_q;
   logic             done_r, done_d;

   assign op_in   = op_e'(op);
   // The single step unit serves both the accept edge and the RUN steps.
   assign step_op = (state == ST_RUN) ? op_r : op_in;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .q     (q_r),
      .op    (step_op),
      .d_sr  (D_sr),
      .d_sl  (D_sl),
      .q_nxt (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         q_r    <= '0;
         rem    <= '0;
         op_r   <= OP_HOLD;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         q_r    <= q_d;
         rem    <= rem_d;
         op_r   <= op_d;
         done_r <= done_d;
      end
   end

   always_comb begin
      state_nxt = state;
      q_d       = q_r;
      rem_d     = rem;
      op_d      = op_r;
      done_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               op_d = op_in;
               if (op_in == OP_LOAD) begin
                  q_d    = D;
                  done_d = 1'b1;
               end else if (is_step_op(op_in) && (cnt != CNT_ZERO)) begin
                  q_d   = step_q;
                  rem_d = cnt - CNT_ONE;
                  if (cnt == CNT_ONE) done_d = 1'b1;
                  else                state_nxt = ST_RUN;
               end else begin
                  // HOLD, cnt=0, illegal code, or a disabled rotate: finish immediately.
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            q_d   = step_q;
            rem_d = rem - CNT_ONE;
            if (rem == CNT_ONE) begin
               state_nxt = ST_IDLE;
               done_d    = 1'b1;
            end
         end
      endcase
   end

   assign Q    = q_r;
   assign so_r = q_r[0];
   assign so_l = q_r[WIDTH-1];
   assign busy = (state == ST_RUN);
   assign done = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus randomized ops
// checked against a closed-form reference model.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [3:0] cnt = 4'd0;
   logic [7:0] D = 8'd0;
   logic       D_sr = 1'b0;
   logic       D_sl = 1'b0;
   logic [7:0] Q;
   logic       so_r, so_l, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .cnt(cnt), .D(D),
      .D_sr(D_sr), .D_sl(D_sl), .Q(Q), .so_r(so_r), .so_l(so_l),
      .busy(busy), .done(done)
   );

   function automatic bit rot_en();
`ifdef USR_ROT_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit is_step(input logic [2:0] o);
      return (o == 3'd2) || (o == 3'd3) || (o == 3'd6) ||
             (rot_en() && ((o == 3'd4) || (o == 3'd5)));
   endfunction

   // Final register value after a whole operation, computed in one go from the op rules.
   function automatic logic [7:0] model_q(input logic [7:0] q, input logic [2:0] o,
                                          input int c, input logic fsr, input logic fsl,
                                          input logic [7:0] d);
      logic [7:0]  ones;
      logic [7:0]  m;
      logic [15:0] dbl;
      int          k;
      ones = 8'hFF;
      if (o == 3'd1) return d;
      if (!is_step(o) || c == 0) return q;
      case (o)
         3'd2: begin
            if (c >= 8) return {8{fsr}};
            m = ones >> c;
            return (q >> c) | (fsr ? ~m : 8'h00);
         end
         3'd3: begin
            if (c >= 8) return {8{fsl}};
            m = ones << c;
            return (q << c) | (fsl ? ~m : 8'h00);
         end
         3'd4: begin
            k = c % 8;
            dbl = {q, q} >> k;
            return dbl[7:0];
         end
         3'd5: begin
            k = c % 8;
            dbl = {q, q} << k;
            return dbl[15:8];
         end
         default: begin
            k = (c > 7) ? 7 : c;
            return 8'($signed(q) >>> k);
         end
      endcase
   endfunction

   function automatic int model_busy(input logic [2:0] o, input int c);
      return (is_step(o) && c >= 2) ? c - 1 : 0;
   endfunction

   // Issue one request and wait for done; returns busy cycles seen and whether it timed out.
   task automatic run_op(input logic [2:0] o, input logic [3:0] c, input logic [7:0] d,
                         output int bc, output bit to);
      op = o; cnt = c; D = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bc = 0; to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            to = 1'b0;
            break;
         end
         if (busy) bc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int bc; bit to; int seen;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", Q); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
      rst = 1'b0;
      run_op(3'd1, 4'd0, 8'h5A, bc, to);
      D_sr = 1'b0;
      op = 3'd2; cnt = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (Q !== 8'h16 || busy !== 1'b1) begin n_err++; $display("FAIL mid_run: got Q=%h busy=%b want 16 1", Q, busy); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL async_reset: got Q=%h busy=%b done=%b want 00 0 0", Q, busy, done);
      end
      #2 rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || busy || Q != 8'h00) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_load();
      int bc; bit to;
      run_op(3'd1, 4'd3, 8'hA5, bc, to);
      n_cmp++; if (to || bc != 0) begin n_err++; $display("FAIL load_timing: got to=%b busy=%0d want 0 0", to, bc); end
      n_cmp++; if (Q !== 8'hA5) begin n_err++; $display("FAIL load_q: got %h want a5", Q); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_shr();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'hD2; exp_q[1] = 8'hE9; exp_q[2] = 8'hF4;
      D_sr = 1'b1;
      op = 3'd2; cnt = 4'd3; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         n_cmp++; if (Q !== exp_q[i]) begin n_err++; $display("FAIL shr_step%0d: got %h want %h", i, Q, exp_q[i]); end
         n_cmp++; if (busy !== (i < 2) || done !== (i == 2)) begin
            n_err++; $display("FAIL shr_flags%0d: got busy=%b done=%b want %b %b", i, busy, done, i < 2, i == 2);
         end
      end
      n_cmp++; if (so_r !== 1'b0 || so_l !== 1'b1) begin n_err++; $display("FAIL shr_serial: got so_r=%b so_l=%b want 0 1", so_r, so_l); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL shr_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_shl_rol();
      int bc; bit to;
      run_op(3'd1, 4'd0, 8'h81, bc, to);
      D_sl = 1'b0;
      run_op(3'd3, 4'd2, 8'h00, bc, to);
      n_cmp++; if (to || Q !== 8'h04 || bc != 1) begin n_err++; $display("FAIL shl: got Q=%h busy=%0d to=%b want 04 1 0", Q, bc, to); end
      run_op(3'd1, 4'd0, 8'h81, bc, to);
      run_op(3'd5, 4'd9, 8'h00, bc, to);
      if (rot_en()) begin
         n_cmp++; if (to || Q !== 8'h03 || bc != 8) begin n_err++; $display("FAIL rol9: got Q=%h busy=%0d want 03 8", Q, bc); end
      end else begin
         n_cmp++; if (to || Q !== 8'h81 || bc != 0) begin n_err++; $display("FAIL rol_disabled: got Q=%h busy=%0d want 81 0", Q, bc); end
      end
   endtask

   task automatic test_asr_busy_start();
      int bc; bit to;
      run_op(3'd1, 4'd0, 8'h80, bc, to);
      op = 3'd6; cnt = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      op = 3'd1; D = 8'h11; cnt = 4'd0;
      @(posedge clk); #1;
      start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (done) begin to = 1'b0; break; end
         @(posedge clk); #1;
      end
      n_cmp++; if (to || Q !== 8'hF8) begin n_err++; $display("FAIL asr_ignore: got Q=%h to=%b want f8 0", Q, to); end
      run_op(3'd1, 4'd0, 8'h11, bc, to);
      n_cmp++; if (to || Q !== 8'h11) begin n_err++; $display("FAIL back_to_back: got Q=%h to=%b want 11 0", Q, to); end
   endtask

   task automatic test_random();
      int bc; bit to;
      logic [2:0] o; logic [3:0] c; logic [7:0] d, q_exp;
      for (int n = 0; n < 60; n++) begin
         o = 3'($urandom_range(0, 7));
         c = 4'($urandom_range(0, 15));
         d = 8'($urandom);
         D_sr = 1'($urandom);
         D_sl = 1'($urandom);
         q_exp = model_q(Q, o, int'(c), D_sr, D_sl, d);
         run_op(o, c, d, bc, to);
         n_cmp++; if (to) begin n_err++; $display("FAIL rnd_timeout%0d: op=%0d cnt=%0d no done", n, o, c); end
         n_cmp++; if (Q !== q_exp) begin n_err++; $display("FAIL rnd_q%0d: op=%0d cnt=%0d got %h want %h", n, o, c, Q, q_exp); end
         n_cmp++; if (bc != model_busy(o, int'(c))) begin
            n_err++; $display("FAIL rnd_busy%0d: op=%0d cnt=%0d got %0d want %0d", n, o, c, bc, model_busy(o, int'(c)));
         end
         n_cmp++; if (so_r !== q_exp[0] || so_l !== q_exp[7]) begin
            n_err++; $display("FAIL rnd_serial%0d: got %b%b want %b%b", n, so_l, so_r, q_exp[7], q_exp[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shr();
      test_shl_rol();
      test_asr_busy_start();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
